// File: rtl/ddr2_app_pkg.sv
// Shared constants and FSM state type for the DDR2 application-side responder.
package ddr2_app_pkg;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    localparam int CMD_W           = 3;
    localparam int ADDR_IN_W       = 31;
    localparam int BEAT_W          = 128;
    localparam int MASK_W          = 16;
    localparam int BEATS_PER_BURST = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR0,
        ST_WR1,
        ST_RD_WAIT,
        ST_RD0,
        ST_RD1
    } resp_state_e;

endpackage

// File: rtl/ddr2_app_responder_if.sv
// app_af / app_wdf / read-return bundle; master = traffic source, slave = responder.
interface ddr2_app_responder_if;
    import ddr2_app_pkg::*;

    logic                 app_af_wren;
    logic [CMD_W-1:0]     app_af_cmd;
    logic [ADDR_IN_W-1:0] app_af_addr;
    logic                 app_af_afull;
    logic                 app_wdf_wren;
    logic [BEAT_W-1:0]    app_wdf_data;
    logic [MASK_W-1:0]    app_wdf_mask_data;
    logic                 app_wdf_afull;
    logic                 rd_data_valid;
    logic [BEAT_W-1:0]    rd_data_fifo_out;
    logic                 phy_init_done;
    logic                 err;

    modport master (
        output app_af_wren, app_af_cmd, app_af_addr, app_wdf_wren, app_wdf_data, app_wdf_mask_data,
        input  app_af_afull, app_wdf_afull, rd_data_valid, rd_data_fifo_out, phy_init_done, err
    );

    modport slave (
        input  app_af_wren, app_af_cmd, app_af_addr, app_wdf_wren, app_wdf_data, app_wdf_mask_data,
        output app_af_afull, app_wdf_afull, rd_data_valid, rd_data_fifo_out, phy_init_done, err
    );

endinterface

// File: rtl/app_sync_fifo.sv
// Single-clock show-ahead FIFO; push to a full FIFO is dropped even when a pop happens the same cycle.
module app_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ddr2_app_responder.sv
// DDR2 application-side responder backed by on-chip line memory.
// Optional sticky error detection is built when DDR2_RESP_ERR_EN is defined.
//
//   state      | meaning
//   ST_IDLE    | pop next command; illegal commands are dropped here
//   ST_WR0     | wait for write beat, commit low half of the line
//   ST_WR1     | wait for write beat, commit high half of the line
//   ST_RD_WAIT | read latency countdown
//   ST_RD0     | return low half, rd_data_valid high
//   ST_RD1     | return high half, rd_data_valid high
module ddr2_app_responder
    import ddr2_app_pkg::*;
#(
    parameter int ADDR_W       = 10,
    parameter int AF_DEPTH     = 8,
    parameter int WDF_DEPTH    = 16,
    parameter int AFULL_MARGIN = 2,
    parameter int RD_LAT       = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ddr2_app_responder_if.slave   app
);

    localparam int CMD_FW = CMD_W + ADDR_IN_W;
    localparam int WDF_FW = BEAT_W + MASK_W;
    localparam int LINES  = 2 ** ADDR_W;
    localparam int AF_CW  = $clog2(AF_DEPTH) + 1;
    localparam int WDF_CW = $clog2(WDF_DEPTH) + 1;
    localparam int LAT_W  = $clog2(RD_LAT + 1);

    resp_state_e state, state_nxt;

    logic [CMD_FW-1:0] af_head;
    logic              af_full, af_empty, af_pop;
    logic [AF_CW-1:0]  af_count;
    logic [WDF_FW-1:0] wdf_head;
    logic              wdf_full, wdf_empty, wdf_pop;
    logic [WDF_CW-1:0] wdf_count;

    logic [CMD_W-1:0]              af_cmd;
    logic [ADDR_W-1:0]             af_idx;
    logic [ADDR_IN_W-ADDR_W-3:0]   af_addr_hi;
    logic [BEAT_W-1:0]             wdf_beat;
    logic [MASK_W-1:0]             wdf_mask;

    logic [ADDR_W-1:0] cur_idx;
    logic [LAT_W-1:0]  lat_cnt;
    logic [BEAT_W-1:0] rd_lo, rd_hi;
    logic              wr_lo, wr_hi;
    logic              init_done_q;
    logic              unused_bits;

    logic [BEAT_W-1:0] mem_lo [LINES];
    logic [BEAT_W-1:0] mem_hi [LINES];

    app_sync_fifo #(.WIDTH(CMD_FW), .DEPTH(AF_DEPTH)) u_af_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (app.app_af_wren),
        .wr_data ({app.app_af_cmd, app.app_af_addr}),
        .pop     (af_pop),
        .rd_data (af_head),
        .full    (af_full),
        .empty   (af_empty),
        .count   (af_count)
    );

    app_sync_fifo #(.WIDTH(WDF_FW), .DEPTH(WDF_DEPTH)) u_wdf_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (app.app_wdf_wren),
        .wr_data ({app.app_wdf_mask_data, app.app_wdf_data}),
        .pop     (wdf_pop),
        .rd_data (wdf_head),
        .full    (wdf_full),
        .empty   (wdf_empty),
        .count   (wdf_count)
    );

    assign af_cmd     = af_head[CMD_FW-1 -: CMD_W];
    assign af_idx     = af_head[ADDR_W+1:2];
    assign af_addr_hi = af_head[ADDR_IN_W-1:ADDR_W+2];
    assign wdf_beat   = wdf_head[BEAT_W-1:0];
    assign wdf_mask   = wdf_head[WDF_FW-1 -: MASK_W];
    assign unused_bits = ^{af_head[1:0], af_addr_hi, af_full, wdf_full};

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        af_pop    = 1'b0;
        wdf_pop   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!af_empty) begin
                    af_pop = 1'b1;
                    if (af_cmd == CMD_WRITE)     state_nxt = ST_WR0;
                    else if (af_cmd == CMD_READ) state_nxt = (RD_LAT > 1) ? ST_RD_WAIT : ST_RD0;
                end
            end
            ST_WR0: begin
                if (!wdf_empty) begin
                    wdf_pop   = 1'b1;
                    state_nxt = ST_WR1;
                end
            end
            ST_WR1: begin
                if (!wdf_empty) begin
                    wdf_pop   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_RD_WAIT: if (lat_cnt == LAT_W'(1)) state_nxt = ST_RD0;
            ST_RD0:     state_nxt = ST_RD1;
            ST_RD1:     state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Down-counter loaded at pop; terminal count 1 hands over to RD0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lat_cnt <= '0;
            cur_idx <= '0;
        end else if (af_pop) begin
            lat_cnt <= LAT_W'(RD_LAT - 1);
            cur_idx <= af_idx;
        end else if (state == ST_RD_WAIT) begin
            lat_cnt <= lat_cnt - LAT_W'(1);
        end
    end

    assign wr_lo = rst_n && wdf_pop && (state == ST_WR0);
    assign wr_hi = rst_n && wdf_pop && (state == ST_WR1);

    // Read snapshot taken at pop so data reflects all earlier commands.
    always_ff @(posedge clk) begin
        if (af_pop) begin
            rd_lo <= mem_lo[af_idx];
            rd_hi <= mem_hi[af_idx];
        end
        for (int b = 0; b < MASK_W; b++) begin
            if (wr_lo && !wdf_mask[b]) mem_lo[cur_idx][8*b +: 8] <= wdf_beat[8*b +: 8];
            if (wr_hi && !wdf_mask[b]) mem_hi[cur_idx][8*b +: 8] <= wdf_beat[8*b +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) init_done_q <= 1'b0;
        else        init_done_q <= 1'b1;
    end

    assign app.phy_init_done    = init_done_q;
    assign app.rd_data_valid    = (state == ST_RD0) || (state == ST_RD1);
    assign app.rd_data_fifo_out = (state == ST_RD0) ? rd_lo :
                                  (state == ST_RD1) ? rd_hi : '0;
    assign app.app_af_afull     = (AF_CW'(AF_DEPTH) - af_count) <= AF_CW'(AFULL_MARGIN);
    assign app.app_wdf_afull    = (WDF_CW'(WDF_DEPTH) - wdf_count) <= WDF_CW'(AFULL_MARGIN);

`ifdef DDR2_RESP_ERR_EN
    logic err_q;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if ((app.app_af_wren && af_full) || (app.app_wdf_wren && wdf_full) ||
                     (af_pop && ((af_cmd != CMD_WRITE && af_cmd != CMD_READ) || (|af_addr_hi)))) begin
            err_q <= 1'b1;
        end
    end
    assign app.err = err_q;
`else
    assign app.err = 1'b0;
`endif

endmodule
